btn_irq_ctrl: RTL and testbench

Button interrupt controller sitting between the four board push-buttons and the four `irq*_btn_i` request lines of the magma SoC. It synchronizes and debounces each button and turns each debounced press into a latched pending event. It gates the pending events with a software-written mask and arbitrates them by fixed priority. It then presents one interrupt at a time to the CPU side with a request/acknowledge handshake.

---
 rtl/btn_irq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_btn_irq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_irq_ctrl.sv
// ---------------------------------------------------------------------------
// btn_irq_ctrl -- button interrupt controller.
//
// Each of the four push-buttons is synchronized, debounced and turned into a
// latched pending event on its debounced rising edge. Pending events are
// gated by a software mask, arbitrated by fixed priority (lowest index wins)
// and presented one at a time to the CPU via a req/ack handshake.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   btn_i[3:0]   raw button levels (async): 0=BTNL 1=BTNU 2=BTNR 3=BTND
//   cfg_we_i     mask write strobe
//   cfg_wdata_i  new mask value (1 = channel enabled)
//   irq_ack_i    CPU acknowledge of the current request
//   irq_req_o    interrupt request
//   irq_code_o   channel index of the current request
//   pend_o       pending bits (independent of the mask)
//   mask_o       current mask
//   btn_db_o     debounced button levels
// ---------------------------------------------------------------------------

// Per-channel lane: 2-flop synchronizer, debouncer and pending latch.
//   btn_i  raw level, clr_i clears pending (from the ack),
//   db_o   debounced level, pend_o pending flag.
module btn_irq_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic clr_i,
    output logic db_o,
    output logic pend_o
);
    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise;

    // Counter only runs while the synchronized level disagrees with the
    // debounced one; any agreement restarts the stability window.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) db_d  = s2_q;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end

    // Pending sets on the same edge the debounced level rises, and a set
    // beats a simultaneous clear from the ack.
    assign rise   = db_d & ~db_q;
    assign pend_d = rise | (pend_q & ~clr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign db_o   = db_q;
    assign pend_o = pend_q;
endmodule

module btn_irq_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [3:0]  MASK_RST        = 4'hF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] btn_i,
    input  logic       cfg_we_i,
    input  logic [3:0] cfg_wdata_i,
    input  logic       irq_ack_i,
    output logic       irq_req_o,
    output logic [1:0] irq_code_o,
    output logic [3:0] pend_o,
    output logic [3:0] mask_o,
    output logic [3:0] btn_db_o
);
    localparam int NUM_LANES = 4;

    typedef enum logic {S_IDLE, S_REQ} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             code_q, code_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic [NUM_LANES-1:0]   pend, db, clr, elig;
    logic [1:0]             win;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        btn_irq_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .btn_i  (btn_i[g]),
            .clr_i  (clr[g]),
            .db_o   (db[g]),
            .pend_o (pend[g])
        );
    end

    assign elig   = pend & mask_q;
    assign mask_d = cfg_we_i ? cfg_wdata_i : mask_q;

    // Fixed priority: scan high to low so the lowest eligible index wins.
    always_comb begin
        win = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--)
            if (elig[i]) win = 2'(i);
    end

    // Once in REQ the request is held regardless of mask or newer events;
    // only the ack releases it.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        clr     = '0;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    code_d  = win;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack_i) begin
                    clr[code_q] = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            mask_q  <= MASK_RST;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            mask_q  <= mask_d;
        end
    end

    assign irq_req_o  = (state_q == S_REQ);
    assign irq_code_o = code_q;
    assign pend_o     = pend;
    assign mask_o     = mask_q;
    assign btn_db_o   = db;
endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Bench for btn_irq_ctrl with DEBOUNCE_CYCLES = 4. Expected request codes are
// queued when buttons are pressed and popped when a request is seen.
module tb_btn_irq_ctrl;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [3:0] btn_i;
    logic       cfg_we_i;
    logic [3:0] cfg_wdata_i;
    logic       irq_ack_i;
    logic       irq_req_o;
    logic [1:0] irq_code_o;
    logic [3:0] pend_o, mask_o, btn_db_o;

    always #5 clk = ~clk;

    btn_irq_ctrl #(.DEBOUNCE_CYCLES(DB), .MASK_RST(4'hF)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .btn_i       (btn_i),
        .cfg_we_i    (cfg_we_i),
        .cfg_wdata_i (cfg_wdata_i),
        .irq_ack_i   (irq_ack_i),
        .irq_req_o   (irq_req_o),
        .irq_code_o  (irq_code_o),
        .pend_o      (pend_o),
        .mask_o      (mask_o),
        .btn_db_o    (btn_db_o)
    );

    int         n_tot = 0;
    int         n_bad = 0;
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string tag, output int waited);
        logic [1:0] e;
        waited = 0;
        while (!irq_req_o && waited < 40) begin
            tick();
            waited++;
        end
        if (!irq_req_o) chk({tag, "_req"}, irq_req_o, 1);
        else if (exp_q.size() == 0) chk({tag, "_sb"}, irq_code_o, 4'hF);
        else begin
            e = exp_q.pop_front();
            chk({tag, "_code"}, irq_code_o, e);
        end
    endtask

    task automatic do_ack(input string tag);
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        chk({tag, "_reqlow"}, irq_req_o, 0);
    endtask

    task automatic wr_mask(input logic [3:0] m);
        cfg_we_i    = 1'b1;
        cfg_wdata_i = m;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    int         w;
    logic [3:0] seen;

    initial begin
        rst_i = 1'b1; btn_i = '0; cfg_we_i = 1'b0; cfg_wdata_i = '0; irq_ack_i = 1'b0;
        tick(3);
        chk("rst_req",  irq_req_o,  0);
        chk("rst_code", irq_code_o, 0);
        chk("rst_pend", pend_o,     0);
        chk("rst_mask", mask_o,     4'hF);
        chk("rst_db",   btn_db_o,   0);
        rst_i = 1'b0;
        tick(2);

        // 1: single press, latency check
        btn_i[0] = 1'b1; exp_q.push_back(2'd0);
        tick(5);
        chk("t1_db_early", btn_db_o, 0);
        tick();
        chk("t1_db",   btn_db_o, 4'b0001);
        chk("t1_pend", pend_o,   4'b0001);
        chk("t1_noreq", irq_req_o, 0);
        wait_req("t1", w);
        chk("t1_lat", w, 1);
        tick(3);
        chk("t1_hold", {irq_req_o, irq_code_o}, 3'b100);
        do_ack("t1");
        chk("t1_pend_clr", pend_o, 0);
        btn_i[0] = 1'b0;
        tick(8);

        // 2: glitch rejection then minimum-length press
        btn_i[2] = 1'b1; tick(3); btn_i[2] = 1'b0;
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen |= pend_o | btn_db_o | {3'b000, irq_req_o};
        end
        chk("t2_glitch", seen, 0);
        btn_i[2] = 1'b1; exp_q.push_back(2'd2);
        tick(4); btn_i[2] = 1'b0;
        tick(2);
        chk("t2_pend", pend_o, 4'b0100);
        wait_req("t2", w);
        chk("t2_lat", w, 1);
        do_ack("t2");
        tick(8);

        // 3: priority, one idle cycle between requests
        btn_i[3] = 1'b1; btn_i[1] = 1'b1;
        exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        wait_req("t3a", w);
        chk("t3_pend", pend_o, 4'b1010);
        do_ack("t3a");
        wait_req("t3b", w);
        chk("t3_gap", w, 1);
        do_ack("t3b");
        chk("t3_pend_clr", pend_o, 0);
        btn_i[3] = 1'b0; btn_i[1] = 1'b0;
        tick(8);

        // 4: masking
        wr_mask(4'b1110);
        chk("t4_mask", mask_o, 4'b1110);
        btn_i[0] = 1'b1;
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen[0] |= irq_req_o;
        end
        chk("t4_pend", pend_o, 4'b0001);
        chk("t4_noreq", seen, 0);
        exp_q.push_back(2'd0);
        wr_mask(4'hF);
        chk("t4_req_w", irq_req_o, 0);
        wait_req("t4", w);
        chk("t4_lat", w, 1);
        do_ack("t4");
        btn_i[0] = 1'b0;
        tick(8);

        // 5a: two presses merged into one request
        btn_i[1] = 1'b1; exp_q.push_back(2'd1);
        tick(8); btn_i[1] = 1'b0; tick(8);
        btn_i[1] = 1'b1; tick(8); btn_i[1] = 1'b0; tick(8);
        wait_req("t5a", w);
        chk("t5a_pend", pend_o, 4'b0010);
        do_ack("t5a");
        chk("t5a_pend_clr", pend_o, 0);
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen[0] |= irq_req_o;
        end
        chk("t5a_once", seen, 0);

        // 5b: re-press whose debounced rise lands on the ack edge
        btn_i[1] = 1'b1; exp_q.push_back(2'd1);
        tick(8);
        wait_req("t5b1", w);
        btn_i[1] = 1'b0; tick(8);
        chk("t5b_db_low", btn_db_o[1], 0);
        btn_i[1] = 1'b1; exp_q.push_back(2'd1);
        tick(5);
        irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
        chk("t5b_reqlow", irq_req_o, 0);
        chk("t5b_pend", pend_o, 4'b0010);
        wait_req("t5b2", w);
        chk("t5b_lat", w, 1);
        do_ack("t5b2");
        chk("t5b_pend_clr", pend_o, 0);
        btn_i[1] = 1'b0;
        tick(8);

        // 6: reset mid-request with the button held
        wr_mask(4'b0111);
        btn_i[2] = 1'b1; exp_q.push_back(2'd2);
        wait_req("t6a", w);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("t6_req",  irq_req_o,  0);
        chk("t6_code", irq_code_o, 0);
        chk("t6_pend", pend_o,     0);
        chk("t6_mask", mask_o,     4'hF);
        chk("t6_db",   btn_db_o,   0);
        tick(5);
        chk("t6_pend_early", pend_o, 0);
        tick();
        chk("t6_pend_again", pend_o, 4'b0100);
        exp_q.push_back(2'd2);
        wait_req("t6b", w);
        chk("t6_lat", w, 1);
        do_ack("t6b");
        btn_i[2] = 1'b0;
        tick(8);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
